// File: rtl/bar_collision_scorer.sv
// Per-frame player/bar collision check with cleared-bar scoring and timed respawn.
// Optional high-score register enabled by defining BAR_COLLISION_HISCORE_EN.
module bar_collision_scorer #(
    parameter int unsigned NUM_BARS       = 6,
    parameter int unsigned COORD_W        = 10,
    parameter int unsigned BAR_X0         = 80,
    parameter int unsigned BAR_PITCH      = 80,
    parameter int unsigned BAR_W          = 80,
    parameter int unsigned PLAYER_HALF    = 20,
    parameter int unsigned SCORE_W        = 10,
    parameter int unsigned RESPAWN_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_BARS*COORD_W-1:0]   bar_top,
    input  logic [NUM_BARS*COORD_W-1:0]   bar_len,
    input  logic [COORD_W-1:0]            player_h,
    input  logic [COORD_W-1:0]            player_v,
    output logic [SCORE_W-1:0]            score,
    output logic                          hit,
    output logic                          reset_player
`ifdef BAR_COLLISION_HISCORE_EN
    ,
    output logic [SCORE_W-1:0]            hiscore
`endif
);

    localparam int unsigned E     = COORD_W + 2;
    localparam int unsigned CNT_W = (RESPAWN_CYCLES < 2) ? 1 : $clog2(RESPAWN_CYCLES + 1);
    localparam int unsigned POP_W = $clog2(NUM_BARS + 1);
    localparam int unsigned SUM_W = SCORE_W + 6;

    typedef enum logic {RESPAWN, PLAY} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_BARS-1:0] passed;
    logic [NUM_BARS-1:0] collide;
    logic [NUM_BARS-1:0] clear_now;

    logic [E-1:0] ph, pv, ph_hi, pv_hi;
    assign ph    = E'(player_h);
    assign pv    = E'(player_v);
    assign ph_hi = ph + E'(PLAYER_HALF);
    assign pv_hi = pv + E'(PLAYER_HALF);

    // All tests are phrased as sums so nothing underflows near coordinate 0.
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam logic [E-1:0] XL   = E'(BAR_X0 + g * BAR_PITCH);
        localparam logic [E-1:0] XR_H = E'(BAR_X0 + g * BAR_PITCH + BAR_W + PLAYER_HALF);
        logic [E-1:0] top, bot_h;
        assign top   = E'(bar_top[g*COORD_W +: COORD_W]);
        assign bot_h = top + E'(bar_len[g*COORD_W +: COORD_W]) + E'(PLAYER_HALF);
        assign collide[g]   = (ph_hi > XL) && (ph < XR_H) && (pv_hi > top) && (pv < bot_h);
        assign clear_now[g] = (ph >= XR_H) && !passed[g];
    end

    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_next;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_BARS; i++)
            pop = pop + POP_W'(clear_now[i]);
        sum = SUM_W'(score) + SUM_W'(pop);
        if (sum > SUM_W'({SCORE_W{1'b1}}))
            score_next = '1;
        else
            score_next = sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RESPAWN;
            cnt          <= CNT_W'(RESPAWN_CYCLES);
            score        <= '0;
            passed       <= '0;
            hit          <= 1'b0;
            reset_player <= 1'b1;
`ifdef BAR_COLLISION_HISCORE_EN
            hiscore      <= '0;
`endif
        end else begin
            hit <= 1'b0;
            case (state)
                RESPAWN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state        <= PLAY;
                        reset_player <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (|collide) begin
                            hit          <= 1'b1;
                            state        <= RESPAWN;
                            cnt          <= CNT_W'(RESPAWN_CYCLES);
                            reset_player <= 1'b1;
                            score        <= '0;
                            passed       <= '0;
`ifdef BAR_COLLISION_HISCORE_EN
                            if (score > hiscore)
                                hiscore <= score;
`endif
                        end else begin
                            passed <= passed | clear_now;
                            score  <= score_next;
                        end
                    end
                end
                default: begin
                    state        <= RESPAWN;
                    cnt          <= CNT_W'(RESPAWN_CYCLES);
                    reset_player <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bar_collision_scorer.sv
// Directed self-checking bench for bar_collision_scorer (default parameters).
module tb_bar_collision_scorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [59:0] bar_top;
    logic [59:0] bar_len;
    logic [9:0]  player_h;
    logic [9:0]  player_v;
    logic [9:0]  score;
    logic        hit;
    logic        reset_player;
`ifdef BAR_COLLISION_HISCORE_EN
    logic [9:0]  hiscore;
`endif

    int total = 0;
    int bad   = 0;

    bar_collision_scorer dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .bar_top      (bar_top),
        .bar_len      (bar_len),
        .player_h     (player_h),
        .player_v     (player_v),
        .score        (score),
        .hit          (hit),
        .reset_player (reset_player)
`ifdef BAR_COLLISION_HISCORE_EN
        ,
        .hiscore      (hiscore)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_far();
        for (int i = 0; i < 6; i++) begin
            bar_top[i*10 +: 10] = 10'd500;
            bar_len[i*10 +: 10] = 10'd10;
        end
    endtask

    task automatic place(input int i, input int top, input int len);
        bar_top[i*10 +: 10] = 10'(top);
        bar_len[i*10 +: 10] = 10'(len);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_score;
        reset    = 1'b1;
        tick     = 1'b0;
        player_h = 10'd40;
        player_v = 10'd20;
        bar_top  = '0;
        bar_len  = '0;
        set_far();

        // Reset state and release
        repeat (3) @(posedge clk);
        #1;
        check("rst_rp", 32'(reset_player), 32'd1);
        check("rst_score", 32'(score), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
`ifdef BAR_COLLISION_HISCORE_EN
        check("rst_hiscore", 32'(hiscore), 32'd0);
`endif
        reset = 1'b0;
        check("rel_rp0", 32'(reset_player), 32'd1);
        step();
        check("rel_rp1", 32'(reset_player), 32'd1);
        step();
        check("rel_rp2", 32'(reset_player), 32'd0);
        check("rel_hit", 32'(hit), 32'd0);

        // Collision with bar 2 at (300,20); bars 0/1 cleared on the same tick
        player_h = 10'd300;
        player_v = 10'd20;
        place(2, 0, 100);
        tick = 1'b1;
        step();
        check("b_hit", 32'(hit), 32'd1);
        check("b_rp", 32'(reset_player), 32'd1);
        check("b_score", 32'(score), 32'd0);
        step();
        check("b_hit_pulse", 32'(hit), 32'd0);
        check("b_rp_c1", 32'(reset_player), 32'd1);
        step();
        check("b_ignore_hit", 32'(hit), 32'd0);
        check("b_rp_c2", 32'(reset_player), 32'd0);
        step();
        check("b_entry_tick_hit", 32'(hit), 32'd1);
        tick = 1'b0;
        step();
        step();
        check("b_rp_done", 32'(reset_player), 32'd0);
        check("b_hit_done", 32'(hit), 32'd0);

        // Sweep across all bars with bars out of vertical reach
        set_far();
        tick = 1'b1;
        for (int ph = 40; ph <= 620; ph += 20) begin
            player_h = 10'(ph);
            step();
            exp_score = 0;
            for (int i = 0; i < 6; i++)
                if (ph >= 180 + 80 * i) exp_score++;
            check($sformatf("sweep_score_%0d", ph), 32'(score), 32'(exp_score));
            check($sformatf("sweep_hit_%0d", ph), 32'(hit), 32'd0);
        end
        player_h = 10'd600;
        step();
        check("sweep_hold", 32'(score), 32'd6);
        tick = 1'b0;

        // Near-zero vertical position against a bar starting at y=0
        player_h = 10'd100;
        player_v = 10'd5;
        place(0, 0, 50);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("lowv_hit", 32'(hit), 32'd1);
        check("lowv_score", 32'(score), 32'd0);
`ifdef BAR_COLLISION_HISCORE_EN
        check("lowv_hiscore", 32'(hiscore), 32'd6);
`endif
        step();
        step();
        check("lowv_rp_done", 32'(reset_player), 32'd0);

        // Score 1, then one tick that clears bar 1 and hits bar 2
        set_far();
        player_h = 10'd200;
        player_v = 10'd20;
        tick = 1'b1;
        step();
        check("e_score1", 32'(score), 32'd1);
        player_h = 10'd300;
        place(2, 0, 100);
        step();
        tick = 1'b0;
        check("e_hit", 32'(hit), 32'd1);
        check("e_score_cleared", 32'(score), 32'd0);
`ifdef BAR_COLLISION_HISCORE_EN
        check("e_hiscore_keep", 32'(hiscore), 32'd6);
`endif
        step();
        step();
        check("e_rp_done", 32'(reset_player), 32'd0);

        // Asynchronous reset in the middle of PLAY
        set_far();
        player_h = 10'd200;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("g_score1", 32'(score), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("g_async_rp", 32'(reset_player), 32'd1);
        check("g_async_score", 32'(score), 32'd0);
`ifdef BAR_COLLISION_HISCORE_EN
        check("g_async_hiscore", 32'(hiscore), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("g_rp_c1", 32'(reset_player), 32'd1);
        step();
        check("g_rp_c2", 32'(reset_player), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bar_collision_scorer.md
# bar_collision_scorer

- Parametrised successor to the fixed six-bar collision/score updater.
- Checks a square player sprite against `NUM_BARS` vertical obstacle bars once per frame strobe.
- Counts bars the player has fully cleared as the score, and runs a timed respawn sequence after a hit.
- Sits between the bar/obstacle generators and the VGA renderer/score display in the game top level.

## Interface
Parameters:
- `NUM_BARS`, 6 — number of bar channels (1–16).
- `COORD_W`, 10 — width of all pixel coordinates.
- `BAR_X0`, 80 — left edge x of bar 0.
- `BAR_PITCH`, 80 — x spacing between successive bar left edges.
- `BAR_W`, 80 — bar width in pixels.
- `PLAYER_HALF`, 20 — half side length of the player square.
- `SCORE_W`, 10 — score width.
- `RESPAWN_CYCLES`, 2 — clock cycles `reset_player` is held after a hit or reset (≥1).

Ports:
- `clk`  in  1  — system clock.
- `reset`  in  1  — asynchronous, active-high.
- `tick`  in  1  — frame strobe; one evaluation per cycle it is high.
- `bar_top`  in  `NUM_BARS*COORD_W`  — packed top y of each bar; bar i is at `[i*COORD_W +: COORD_W]`.
- `bar_len`  in  `NUM_BARS*COORD_W`  — packed vertical length of each bar.
- `player_h`  in  `COORD_W`  — player centre x.
- `player_v`  in  `COORD_W`  — player centre y.
- `score`  out  `SCORE_W`  — bars cleared since the last respawn.
- `hit`  out  1  — one-cycle pulse on collision.
- `reset_player`  out  1  — high while in RESPAWN.
- `hiscore`  out  `SCORE_W`  — present only with `HISCORE_EN`.

## Operation
- FSM states: RESPAWN, PLAY.
- Reset → RESPAWN, `cnt=RESPAWN_CYCLES`, `score=0`, `passed=0`, `hit=0`, `reset_player=1`, `hiscore=0`.
- RESPAWN:
  - `cnt` decrements every clock; at `cnt==1` the next state is PLAY and `reset_player` drops.
  - `tick` is ignored.
- PLAY, on `tick`, evaluated for every bar i:
  - `xl = BAR_X0 + i*BAR_PITCH`, `xr = xl + BAR_W`.
  - Horizontal overlap: `player_h + PLAYER_HALF > xl` and `player_h < xr + PLAYER_HALF`.
  - Vertical overlap: `player_v + PLAYER_HALF > bar_top[i]` and `player_v < bar_top[i] + bar_len[i] + PLAYER_HALF`.
  - Collision on bar i requires both overlaps.
  - Bar i is cleared when `player_h >= xr + PLAYER_HALF` and `passed[i]==0`; this sets `passed[i]`.
- Arithmetic:
  - All comparisons use `COORD_W+2`-bit unsigned sums; no subtraction, so no underflow near 0.
  - Bar geometry constants are computed at elaboration.
- Any collision:
  - `hit` pulses for one cycle; next state is RESPAWN with `cnt` reloaded.
  - `score` and `passed` are cleared.
- No collision: `score += popcount(newly cleared)`, saturating at `2^SCORE_W-1`.
- Simultaneous clear and collision on the same tick: collision wins; the score is cleared, not incremented.
- All bars passed: score holds; no wrap.

## Timing
- All outputs are registered.
- `hit`, `score` and `reset_player` update on the clock edge where `tick` is sampled high (latency 1 cycle from the `tick` cycle).
- `reset_player` is high for exactly `RESPAWN_CYCLES` cycles after a hit edge, or after reset deassertion.
- A `tick` arriving on the cycle PLAY is entered is evaluated.
- Back-to-back ticks are each evaluated.
- Reset mid-RESPAWN or mid-PLAY restarts RESPAWN with a full count.

## Configuration
- `BAR_COLLISION_HISCORE_EN` defined:
  - Adds the `hiscore` port and register.
  - On a collision edge, `hiscore <= max(hiscore, score)` using the pre-clear score.
  - Cleared only by `reset`.
- Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Release reset, no ticks → `reset_player` high for 2 cycles then low; `score=0`, `hit=0`.
- Player (300,20), bar 2 top=0 len=100, tick → `hit` one cycle; `reset_player` high 2 cycles; `score=0`.
- Bars placed away from the player, move `player_h` 40→620 in 20-px ticks → `score` reaches 6 and holds; each bar is counted once.
- `player_v=5` with a bar at top=0 → collision detected; no underflow false-miss.
- Same tick clears bar 1 and collides with bar 2 → `hit`=1, `score=0`.
- With `HISCORE_EN`: score 4 then hit → `hiscore=4`; score 2 then hit → `hiscore` stays 4; reset → 0.
